gate_sweep_controller: RTL and testbench

- Self-checking sequencer for the 2-input basic-gate cells (AND/OR/NOT/NAND/NOR/XOR/XNOR).
- On a start pulse it drives the gate under test through all four input vectors, holds each vector for a programmable settle time, and samples the gate output.
- It captures the observed truth table, compares it against the expected table for the selected opcode, and reports pass/fail per vector.
- Sits beside a gate instance as its stimulus/checker controller, replacing hand-written per-gate stimulus.

---
 rtl/gate_pkg.sv | 29 ++
 rtl/gate_expected_lut.sv | 27 ++
 rtl/gate_sweep_controller.sv | 110 +++++++++++
 tb/tb_gate_sweep_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared opcodes, expected truth tables and sweep FSM encoding for the
// basic-gate sweep controller.
package gate_pkg;

  localparam int OP_AND     = 0;
  localparam int OP_OR      = 1;
  localparam int OP_NOT     = 2;
  localparam int OP_NAND    = 3;
  localparam int OP_NOR     = 4;
  localparam int OP_XOR     = 5;
  localparam int OP_XNOR    = 6;
  localparam int OP_ILLEGAL = 7;

  // bit v of each table is Y for input vector v = {a,b}
  localparam logic [3:0] EXP_AND  = 4'b1000;
  localparam logic [3:0] EXP_OR   = 4'b1110;
  localparam logic [3:0] EXP_NOT  = 4'b0011;
  localparam logic [3:0] EXP_NAND = 4'b0111;
  localparam logic [3:0] EXP_NOR  = 4'b0001;
  localparam logic [3:0] EXP_XOR  = 4'b0110;
  localparam logic [3:0] EXP_XNOR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_expected_lut.sv
// Opcode -> expected 4-entry truth table; anything past XNOR is illegal.
module gate_expected_lut
  import gate_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] op,
  output logic [3:0]      expected,
  output logic            illegal
);

  always_comb begin
    expected = 4'b0000;
    illegal  = 1'b0;
    case (int'(op))
      OP_AND:  expected = EXP_AND;
      OP_OR:   expected = EXP_OR;
      OP_NOT:  expected = EXP_NOT;
      OP_NAND: expected = EXP_NAND;
      OP_NOR:  expected = EXP_NOR;
      OP_XOR:  expected = EXP_XOR;
      OP_XNOR: expected = EXP_XNOR;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_sweep_controller.sv
// Drives a 2-input gate through vectors 00..11, samples Y after a settle
// time, and compares the captured truth table against the opcode's table.
module gate_sweep_controller
  import gate_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int OP_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  output logic            gate_a,
  output logic            gate_b,
  input  logic            gate_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            err,
  output logic [3:0]      tt,
  output logic [3:0]      fail_mask
);

  state_t          state, state_next;
  logic [OP_W-1:0] op_q, lut_op;
  logic [3:0]      expected, tt_cap;
  logic            illegal, last_hold;
  logic [1:0]      vec;
  logic [7:0]      hold;

  // IDLE decodes the incoming op to decide DRIVE vs DONE; afterwards the latched op
  assign lut_op    = (state == ST_IDLE) ? op : op_q;
  assign last_hold = (hold == 8'(HOLD_CYCLES - 1));

  gate_expected_lut #(.OP_W(OP_W)) u_lut (
    .op       (lut_op),
    .expected (expected),
    .illegal  (illegal)
  );

  always_comb begin
    tt_cap      = tt;
    tt_cap[vec] = gate_y;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    case (state)
      ST_IDLE:  if (start) state_next = illegal ? ST_DONE : ST_DRIVE;
      ST_DRIVE: if (last_hold && vec == 2'd3) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      vec       <= 2'd0;
      hold      <= 8'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      pass      <= 1'b0;
      err       <= 1'b0;
      tt        <= 4'h0;
      fail_mask <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op_q      <= op;
          vec       <= 2'd0;
          hold      <= 8'd0;
          gate_a    <= 1'b0;
          gate_b    <= 1'b0;
          tt        <= 4'h0;
          pass      <= 1'b0;
          err       <= illegal;
          fail_mask <= illegal ? 4'hF : 4'h0;
        end
        ST_DRIVE: begin
          if (last_hold) begin
            tt   <= tt_cap;
            hold <= 8'd0;
            if (vec == 2'd3) begin
              // last sample lands here, so results are valid in the DONE cycle
              fail_mask <= tt_cap ^ expected;
              pass      <= ((tt_cap ^ expected) == 4'h0);
              gate_a    <= 1'b0;
              gate_b    <= 1'b0;
            end else begin
              vec              <= vec + 2'd1;
              {gate_a, gate_b} <= vec + 2'd1;
            end
          end else begin
            hold <= hold + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Directed bench: one controller with 2-cycle hold, one with 1-cycle hold,
// each wired to a behavioural gate cell selected by the bench.
module tb_gate_sweep_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [2:0] op0, op1;
  logic       a0, b0, y0, busy0, done0, pass0, err0;
  logic       a1, b1, y1, busy1, done1, pass1, err1;
  logic [3:0] tt0, fm0, tt1, fm1;
  int         cell0, cell1;
  int         n_chk = 0, n_pass = 0;
  int         got, seen;

  // 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR
  function automatic logic gate_fn(int c, logic a, logic b);
    case (c)
      0:       return a & b;
      1:       return a | b;
      2:       return ~a;
      3:       return ~(a & b);
      4:       return ~(a | b);
      5:       return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign y0 = gate_fn(cell0, a0, b0);
  assign y1 = gate_fn(cell1, a1, b1);

  gate_sweep_controller #(.HOLD_CYCLES(2), .OP_W(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op0),
    .gate_a(a0), .gate_b(b0), .gate_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err(err0),
    .tt(tt0), .fail_mask(fm0)
  );

  gate_sweep_controller #(.HOLD_CYCLES(1), .OP_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1),
    .gate_a(a1), .gate_b(b1), .gate_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err(err1),
    .tt(tt1), .fail_mask(fm1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pulse start on dut0 and return the cycle (1 = after accepting edge) of done
  task automatic sweep0(input logic [2:0] o, output int done_cyc);
    op0 = o; start0 = 1'b1;
    step();
    start0 = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done0) begin done_cyc = c; break; end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; op0 = 3'd0; op1 = 3'd0;
    cell0 = 0; cell1 = 2;
    step(); step();
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ab", {a0, b0}, 2'b00);
    chk("rst_res", {pass0, err0, tt0, fm0}, 10'h0);
    rst = 1'b0;
    step();

    // AND cell, op AND; a second start mid-sweep (with op=7) and one in DONE are ignored
    cell0 = 0; op0 = 3'd0; start0 = 1'b1;
    step();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("and_ab_c%0d", c), {a0, b0}, (c - 1) / 2);
      chk($sformatf("and_busy_c%0d", c), busy0, 1'b1);
      chk($sformatf("and_done_c%0d", c), done0, 1'b0);
      if (c == 3) begin start0 = 1'b1; op0 = 3'd7; end
      else start0 = 1'b0;
      step();
    end
    chk("and_done", done0, 1'b1);
    chk("and_busy_done", busy0, 1'b1);
    chk("and_ab_done", {a0, b0}, 2'b00);
    chk("and_tt", tt0, 4'b1000);
    chk("and_fm", fm0, 4'b0000);
    chk("and_pass", pass0, 1'b1);
    chk("and_err", err0, 1'b0);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("and_idle_busy", busy0, 1'b0);
    chk("and_idle_done", done0, 1'b0);
    step();
    chk("and_noqueue_busy", busy0, 1'b0);
    chk("and_hold_tt", tt0, 4'b1000);
    chk("and_hold_pass", pass0, 1'b1);

    // op XOR expected, AND cell connected
    cell0 = 0;
    sweep0(3'd5, got);
    chk("xor_lat", got, 9);
    chk("xor_tt", tt0, 4'b1000);
    chk("xor_fm", fm0, 4'b1110);
    chk("xor_pass", pass0, 1'b0);
    step();

    // NOT cell on the 1-cycle-hold instance
    op1 = 3'd2; cell1 = 2; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("not_ab_c%0d", c), {a1, b1}, c - 1);
      chk($sformatf("not_done_c%0d", c), done1, 1'b0);
      step();
    end
    chk("not_done", done1, 1'b1);
    chk("not_tt", tt1, 4'b0011);
    chk("not_fm", fm1, 4'b0000);
    chk("not_pass", pass1, 1'b1);
    step();

    // illegal opcode
    sweep0(3'd7, got);
    chk("ill_lat", got, 1);
    chk("ill_err", err0, 1'b1);
    chk("ill_pass", pass0, 1'b0);
    chk("ill_fm", fm0, 4'hF);
    chk("ill_tt", tt0, 4'h0);
    chk("ill_ab", {a0, b0}, 2'b00);
    step();
    chk("ill_idle_busy", busy0, 1'b0);
    chk("ill_hold_err", err0, 1'b1);

    // reset while vector 2 is driven
    cell0 = 6; op0 = 3'd0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    step(); step(); step(); step();
    chk("rst_mid_ab_pre", {a0, b0}, 2'b10);
    rst = 1'b1;
    step();
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_ab", {a0, b0}, 2'b00);
    chk("rst_mid_done", done0, 1'b0);
    chk("rst_mid_tt", tt0, 4'h0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done0 || busy0) seen++;
      step();
    end
    chk("rst_mid_nodone", seen, 0);

    // full sweep after reset, XNOR cell
    sweep0(3'd6, got);
    chk("xnor_lat", got, 9);
    chk("xnor_tt", tt0, 4'b1001);
    chk("xnor_fm", fm0, 4'b0000);
    chk("xnor_pass", pass0, 1'b1);
    chk("xnor_err", err0, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
